// File: rtl/i2c_cmd_arbiter.sv
// Purpose: shares one I2C write master between the config sequencer (cfg) and the runtime user path (usr).
// Latency: req sampled in IDLE -> i2c_exec next cycle; i2c_done sampled -> *_ack next cycle; GAP_CYCLES idle after ack.
// Backpressure: requesters hold req until ack; usr is locked out until cfg_done; requests are not sampled in ACK/GAP.
module i2c_cmd_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        clk_i2c,
  input  logic        rst,
  input  logic        cfg_done,
  input  logic        cfg_req,
  input  logic [15:0] cfg_data,
  output logic        cfg_ack,
  output logic        cfg_err,
  input  logic        usr_req,
  input  logic [15:0] usr_data,
  output logic        usr_ack,
  output logic        usr_err,
  output logic        i2c_exec,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ACK   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT_CYCLES);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic        owner_usr;   // 1: current transaction belongs to usr
  logic        last_usr;    // 1: usr was granted most recently
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_nxt;
  logic [7:0]  gap_cnt;
  logic        elig_cfg;
  logic        elig_usr;
  logic        pick_usr;
  logic        wait_fin;
  logic        fin_err;

  // Eligibility and round-robin pick: usr wins only if cfg is absent or cfg went last.
  always_comb begin
    elig_cfg = cfg_req;
    elig_usr = usr_req & cfg_done;
    pick_usr = elig_usr & (~elig_cfg | ~last_usr);
    tmo_nxt  = tmo_cnt + 16'd1;
    // A done in the same cycle the watchdog expires takes precedence.
    wait_fin = i2c_done | (tmo_nxt == TMO_LIM);
    fin_err  = i2c_done ? i2c_nack : 1'b1;
  end

  // Arbiter FSM with all outputs registered; ack/err/exec default low so they pulse for one cycle.
  always_ff @(posedge clk_i2c or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_usr <= 1'b0;
      last_usr  <= 1'b1;
      tmo_cnt   <= 16'd0;
      gap_cnt   <= 8'd0;
      i2c_exec  <= 1'b0;
      i2c_data  <= 16'h0000;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      usr_ack   <= 1'b0;
      usr_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      i2c_exec <= 1'b0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
      usr_ack  <= 1'b0;
      usr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_cfg | elig_usr) begin
            i2c_data  <= pick_usr ? usr_data : cfg_data;
            owner_usr <= pick_usr;
            last_usr  <= pick_usr;
            i2c_exec  <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt <= 16'd0;
          state   <= WAIT;
        end
        WAIT: begin
          // Counter never passes the limit because WAIT is left on reaching it.
          tmo_cnt <= tmo_nxt;
          if (wait_fin) begin
            cfg_ack <= ~owner_usr;
            cfg_err <= ~owner_usr & fin_err;
            usr_ack <= owner_usr;
            usr_err <= owner_usr & fin_err;
            state   <= ACK;
          end
        end
        ACK: begin
          gap_cnt <= 8'd0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Purpose: randomized bench for i2c_cmd_arbiter against a transaction/timestamp reference model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: requester agents hold req until ack; an I2C master agent answers each exec.
module tb_i2c_cmd_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 4095;

  logic        clk_i2c = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_done = 1'b0;
  logic        cfg_req = 1'b0;
  logic [15:0] cfg_data = 16'h0;
  logic        usr_req = 1'b0;
  logic [15:0] usr_data = 16'h0;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        cfg_ack, cfg_err, usr_ack, usr_err, i2c_exec, busy;
  logic [15:0] i2c_data;

  i2c_cmd_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i2c (clk_i2c),
    .rst     (rst),
    .cfg_done(cfg_done),
    .cfg_req (cfg_req),
    .cfg_data(cfg_data),
    .cfg_ack (cfg_ack),
    .cfg_err (cfg_err),
    .usr_req (usr_req),
    .usr_data(usr_data),
    .usr_ack (usr_ack),
    .usr_err (usr_err),
    .i2c_exec(i2c_exec),
    .i2c_data(i2c_data),
    .i2c_done(i2c_done),
    .i2c_nack(i2c_nack),
    .busy    (busy)
  );

  always #5 clk_i2c = ~clk_i2c;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: timestamps of grants/completions rather than FSM states.
  int          e = 0;          // rising-edge counter
  bit          inflight = 0;
  int          g = 0;          // edge at which the current transaction was granted
  int          next_ok = 0;    // earliest edge a new grant may happen
  bit          last = 1;       // 1 = usr granted last
  bit          owner = 0;      // 1 = usr owns current transaction
  logic [15:0] held = 16'h0;

  // Observations
  logic [15:0] exec_log[$];
  int          obs_last_exec = -1;
  bit          saw_ack = 0;
  bit          ack_usr = 0;
  bit          ack_err = 0;

  // Agents
  logic        req_v[2];
  logic [15:0] dat_v[2];
  bit          pend[2];
  bit          hold[2];
  bit          raise_en[2];
  int          drop_pct = 0;
  bit          stray_en = 0;
  bit          cd_rand = 0;
  int          mmode = 0;      // 0 random delay, 1 silent, 2 done exactly at timeout, 3 fixed delay
  int          mdelay = 20;
  int          mnack = 0;      // <0 random
  bit          serving = 0;
  int          tgt = 0;
  bit          cur_nack = 0;

  task automatic model_reset();
    inflight = 0;
    next_ok  = 0;
    last     = 1;
    owner    = 0;
    held     = 16'h0;
  endtask

  task automatic drive();
    cfg_req  = req_v[0];
    cfg_data = dat_v[0];
    usr_req  = req_v[1];
    usr_data = dat_v[1];
  endtask

  task automatic raise(input int r, input logic [15:0] d);
    req_v[r] = 1'b1;
    dat_v[r] = d;
    pend[r]  = 1'b1;
    drive();
  endtask

  task automatic model_check(input logic c_req, input logic u_req, input logic cd,
                             input logic dn, input logic nk,
                             input logic [15:0] cdat, input logic [15:0] udat);
    logic x_exec, x_cack, x_cerr, x_uack, x_uerr, x_busy, fin, ferr, el_c, el_u, win;
    x_exec = 0; x_cack = 0; x_cerr = 0; x_uack = 0; x_uerr = 0; fin = 0; ferr = 0;
    if (inflight) begin
      // Edge g+1 is the issue cycle; WAIT edges start at g+2.
      if (e >= g + 2) begin
        if (dn) begin
          fin = 1; ferr = nk;
        end else if (e - g - 1 == TMO) begin
          fin = 1; ferr = 1;
        end
      end
      if (fin) begin
        inflight = 0;
        next_ok  = e + 2 + GAP;
        if (owner) begin x_uack = 1; x_uerr = ferr; end
        else begin x_cack = 1; x_cerr = ferr; end
      end
    end else if (e >= next_ok) begin
      el_c = c_req;
      el_u = u_req & cd;
      if (el_c | el_u) begin
        win      = (el_c & el_u) ? ~last : el_u;
        owner    = win;
        last     = win;
        held     = win ? udat : cdat;
        inflight = 1;
        g        = e;
        x_exec   = 1;
      end
    end
    x_busy = inflight | fin | (e < next_ok - 1);
    check_eq("exec", 32'(i2c_exec), 32'(x_exec));
    check_eq("i2c_data", 32'(i2c_data), 32'(held));
    check_eq("busy", 32'(busy), 32'(x_busy));
    check_eq("cfg_ack", 32'(cfg_ack), 32'(x_cack));
    check_eq("cfg_err", 32'(cfg_err), 32'(x_cerr));
    check_eq("usr_ack", 32'(usr_ack), 32'(x_uack));
    check_eq("usr_err", 32'(usr_err), 32'(x_uerr));
  endtask

  task automatic agents();
    int  d;
    bit  a;
    // Requesters
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? cfg_ack : usr_ack;
      if (a) begin
        if (hold[r]) pend[r] = 1;
        else begin
          pend[r]  = 0;
          req_v[r] = 1'b0;
        end
      end else if (i2c_exec && (int'(owner) == r) && !hold[r] &&
                   ($urandom_range(99) < drop_pct)) begin
        req_v[r] = 1'b0;
      end
      if (!req_v[r] && !pend[r] && raise_en[r] && ($urandom_range(15) == 0)) begin
        req_v[r] = 1'b1;
        dat_v[r] = 16'($urandom);
        pend[r]  = 1;
      end
    end
    if (cd_rand && ($urandom_range(63) == 0)) cfg_done = ~cfg_done;
    // I2C master
    if (cfg_ack | usr_ack) serving = 0;
    if (serving && (e >= tgt)) serving = 0;
    if (i2c_exec) begin
      case (mmode)
        1:       d = 100000;
        2:       d = TMO;
        3:       d = mdelay;
        default: d = $urandom_range(30, 1);
      endcase
      serving  = 1;
      tgt      = e + 1 + d;
      cur_nack = (mnack < 0) ? 1'($urandom_range(1)) : 1'(mnack);
    end
    if (serving) i2c_done = (e + 1 == tgt);
    else         i2c_done = stray_en && ($urandom_range(11) == 0);
    i2c_nack = (i2c_done && serving) ? cur_nack : 1'($urandom_range(1));
    drive();
  endtask

  task automatic tick();
    logic c_req, u_req, cd, dn, nk;
    logic [15:0] cdat, udat;
    c_req = cfg_req; u_req = usr_req; cd = cfg_done; dn = i2c_done; nk = i2c_nack;
    cdat = cfg_data; udat = usr_data;
    @(posedge clk_i2c);
    e++;
    @(negedge clk_i2c);
    model_check(c_req, u_req, cd, dn, nk, cdat, udat);
    if (i2c_exec) begin
      if (obs_last_exec >= 0)
        check_eq("exec_spacing", 32'((e - obs_last_exec) >= 3 + GAP), 32'd1);
      obs_last_exec = e;
      exec_log.push_back(i2c_data);
    end
    if (cfg_ack | usr_ack) begin
      saw_ack = 1;
      ack_usr = usr_ack;
      ack_err = cfg_ack ? cfg_err : usr_err;
    end
    agents();
  endtask

  task automatic run_ack(input int bound, input string tag, input bit x_usr, input bit x_err);
    int n;
    n = 0;
    saw_ack = 0;
    while (!saw_ack && (n < bound)) begin
      tick();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(saw_ack), 32'd1);
    check_eq({tag, "_owner"}, 32'(ack_usr), 32'(x_usr));
    check_eq({tag, "_err"}, 32'(ack_err), 32'(x_err));
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_exec"}, 32'(i2c_exec), 32'd0);
    check_eq({pfx, "_data"}, 32'(i2c_data), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_cfg_ack"}, 32'(cfg_ack), 32'd0);
    check_eq({pfx, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check_eq({pfx, "_usr_ack"}, 32'(usr_ack), 32'd0);
    check_eq({pfx, "_usr_err"}, 32'(usr_err), 32'd0);
  endtask

  initial begin
    logic [15:0] rr_exp[4];
    int n;
    for (int r = 0; r < 2; r++) begin
      req_v[r] = 0; dat_v[r] = 0; pend[r] = 0; hold[r] = 0; raise_en[r] = 0;
    end
    model_reset();
    #1 rst = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (2) @(posedge clk_i2c);
    @(negedge clk_i2c);
    rst = 1'b0;

    // Single cfg request during lockout; usr held the whole time.
    cfg_done = 0;
    mmode = 3; mdelay = 20; mnack = 0;
    raise(0, 16'h1E00);
    raise(1, 16'h0778);
    run_ack(200, "cfg_single", 0, 0);
    repeat (500) tick();
    check_eq("lockout_execs", 32'(exec_log.size()), 32'd1);
    check_eq("cfg_single_data", 32'(exec_log.size() > 0 ? exec_log[0] : 16'hDEAD), 32'h1E00);
    cfg_done = 1;
    run_ack(100, "lockout_release", 1, 0);
    repeat (20) tick();
    check_eq("usr_single_execs", 32'(exec_log.size()), 32'd2);
    check_eq("usr_single_data", 32'(exec_log.size() > 1 ? exec_log[1] : 16'hDEAD), 32'h0778);

    // Round-robin with both requesters held continuously.
    mmode = 0;
    exec_log.delete();
    hold[0] = 1; hold[1] = 1;
    raise(0, 16'h0578);
    raise(1, 16'h0778);
    repeat (300) tick();
    rr_exp = '{16'h0578, 16'h0778, 16'h0578, 16'h0778};
    for (int i = 0; i < 4; i++)
      check_eq("rr_order", 32'(exec_log.size() > i ? exec_log[i] : 16'hDEAD), 32'(rr_exp[i]));
    hold[0] = 0; hold[1] = 0;
    repeat (150) tick();

    // Error paths: NACK, pure timeout, done coincident with timeout.
    mnack = 1;
    raise(1, 16'h0A55);
    run_ack(100, "usr_nack", 1, 1);
    repeat (10) tick();
    mnack = 0; mmode = 1;
    raise(0, 16'h0C01);
    run_ack(TMO + 100, "cfg_timeout", 0, 1);
    repeat (10) tick();
    mmode = 2;
    raise(0, 16'h0C02);
    run_ack(TMO + 100, "tmo_coincide", 0, 0);
    repeat (10) tick();

    // Stray done pulses with nobody requesting.
    mmode = 0; stray_en = 1;
    saw_ack = 0;
    repeat (60) tick();
    check_eq("stray_no_ack", 32'(saw_ack), 32'd0);

    // Random traffic: cfg_done toggling, drop-after-grant, random NACK, stray done.
    raise_en[0] = 1; raise_en[1] = 1; drop_pct = 30; mnack = -1; cd_rand = 1;
    repeat (6000) tick();
    raise_en[0] = 0; raise_en[1] = 0; cd_rand = 0; cfg_done = 1; stray_en = 0;
    repeat (300) tick();

    // Reset while waiting on the I2C master.
    mmode = 1; mnack = 0;
    hold[0] = 1; hold[1] = 1;
    raise(0, 16'h1234);
    raise(1, 16'h5678);
    n = 0;
    while (!(inflight && (e >= g + 2)) && (n < 300)) begin
      tick();
      n++;
    end
    check_eq("rst_reach_wait", 32'(inflight && (e >= g + 2)), 32'd1);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1 check_outputs_zero("rst_wait");
    repeat (2) @(posedge clk_i2c);
    @(negedge clk_i2c);
    check_outputs_zero("rst_hold");
    model_reset();
    serving = 0; mmode = 0;
    i2c_done = 0;
    obs_last_exec = -1;
    exec_log.delete();
    rst = 1'b0;
    repeat (30) tick();
    check_eq("post_rst_first", 32'(exec_log.size() > 0 ? exec_log[0] : 16'hDEAD), 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
